router_pkt_gen: RTL and testbench

- Upstream source stage for router_top. Buffers a payload written by a host, then on command serialises one router packet onto the router input: header, payload, then parity.
- Header byte is {len[5:0], addr[1:0]}. Parity byte is the XOR of the header and all payload bytes.
- Owns the router input-side protocol: pkt_valid framing and stalling on busy. Host logic never needs to know router timing.

---
 rtl/router_pkg.sv | 22 ++
 rtl/router_pkt_gen_if.sv | 28 ++
 rtl/router_byte_fifo.sv | 50 +++++
 rtl/router_pkt_gen.sv | 152 +++++++++++++++
 tb/tb_router_pkt_gen.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// Shared constants, FSM state type and header packing for the router packet generator.
package router_pkg;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned LEN_W  = 6;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PLD,
        PAR,
        GAP
    } tx_state_e;

    function automatic logic [7:0] pack_header(input logic [LEN_W-1:0]  len,
                                               input logic [ADDR_W-1:0] addr);
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_pkt_gen_if.sv
// Host-side and router-side signals of the packet generator, grouped with direction views.
interface router_pkt_gen_if;
    import router_pkg::*;

    logic [7:0]        pld_data;
    logic              pld_valid;
    logic              pld_ready;
    logic              tx_start;
    logic [ADDR_W-1:0] tx_addr;
    logic [LEN_W-1:0]  tx_len;
    logic              tx_idle;
    logic              cmd_err;
    logic              tx_done;
    logic              busy;
    logic [7:0]        data_in;
    logic              pkt_valid;

    modport master (
        input  pld_data, pld_valid, tx_start, tx_addr, tx_len, busy,
        output pld_ready, tx_idle, cmd_err, tx_done, data_in, pkt_valid
    );

    modport slave (
        output pld_data, pld_valid, tx_start, tx_addr, tx_len, busy,
        input  pld_ready, tx_idle, cmd_err, tx_done, data_in, pkt_valid
    );

endinterface

// File: rtl/router_byte_fifo.sv
// Byte FIFO with show-ahead read data; push is ignored when full, pop when empty.
module router_byte_fifo #(
    parameter  int unsigned DEPTH = 64,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [7:0]    din_i,
    output logic [7:0]    dout_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/router_pkt_gen.sv
// Buffers host payload and serialises one router packet (header, payload, parity) per command,
// stalling on router busy and inserting a fixed idle gap after each packet.
module router_pkt_gen
    import router_pkg::*;
#(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic              clock,
    input  logic              resetn,
    router_pkt_gen_if.master  bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    tx_state_e         state_q, state_d;
    logic [7:0]        data_q, data_d;
    logic              pkt_valid_q, pkt_valid_d;
    logic              tx_done_q, tx_done_d;
    logic              cmd_err_q, cmd_err_d;
    logic [7:0]        parity_q, parity_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [GW-1:0]     gap_cnt_q, gap_cnt_d;

    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;
    logic          pop_req;

    logic accept, last_byte, cmd_ok, gap_done;

    router_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .resetn  (resetn),
        .push_i  (bus.pld_valid),
        .pop_i   (pop_req && !fifo_empty),
        .din_i   (bus.pld_data),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.pld_ready = !fifo_full;
    assign bus.tx_idle   = (state_q == IDLE);
    assign bus.data_in   = data_q;
    assign bus.pkt_valid = pkt_valid_q;
    assign bus.tx_done   = tx_done_q;
    assign bus.cmd_err   = cmd_err_q;

    assign accept    = (state_q inside {HDR, PLD, PAR}) && !bus.busy;
    assign last_byte = (rem_q == LEN_W'(1));
    assign gap_done  = (gap_cnt_q == GW'(GAP_CYCLES - 1));
    assign cmd_ok    = (bus.tx_addr != ADDR_INVALID) && (bus.tx_len != '0) &&
                       (fifo_count >= CW'(bus.tx_len));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.tx_start && cmd_ok) state_d = HDR;
            HDR:  if (accept) state_d = PLD;
            PLD:  if (accept && last_byte) state_d = PAR;
            PAR:  if (accept) state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP:  if (gap_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The byte after the one being accepted is popped in the same cycle, so data_in never bubbles.
    always_comb begin
        data_d      = data_q;
        pkt_valid_d = pkt_valid_q;
        parity_d    = parity_q;
        rem_d       = rem_q;
        gap_cnt_d   = gap_cnt_q;
        tx_done_d   = 1'b0;
        cmd_err_d   = 1'b0;
        pop_req     = 1'b0;
        unique case (state_q)
            IDLE: begin
                gap_cnt_d = '0;
                if (bus.tx_start) begin
                    if (cmd_ok) begin
                        data_d      = pack_header(bus.tx_len, bus.tx_addr);
                        parity_d    = pack_header(bus.tx_len, bus.tx_addr);
                        pkt_valid_d = 1'b1;
                        rem_d       = bus.tx_len;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            HDR: begin
                if (accept) begin
                    pop_req = 1'b1;
                    data_d  = fifo_dout;
                end
            end
            PLD: begin
                if (accept) begin
                    parity_d = parity_q ^ data_q;
                    rem_d    = rem_q - LEN_W'(1);
                    if (last_byte) begin
                        data_d      = parity_q ^ data_q;
                        pkt_valid_d = 1'b0;
                    end else begin
                        pop_req = 1'b1;
                        data_d  = fifo_dout;
                    end
                end
            end
            PAR: begin
                if (accept) begin
                    tx_done_d = 1'b1;
                    data_d    = '0;
                    gap_cnt_d = '0;
                end
            end
            GAP: gap_cnt_d = gap_cnt_q + GW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            data_q      <= '0;
            pkt_valid_q <= 1'b0;
            parity_q    <= '0;
            rem_q       <= '0;
            gap_cnt_q   <= '0;
            tx_done_q   <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            data_q      <= data_d;
            pkt_valid_q <= pkt_valid_d;
            parity_q    <= parity_d;
            rem_q       <= rem_d;
            gap_cnt_q   <= gap_cnt_d;
            tx_done_q   <= tx_done_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

endmodule

// File: tb/tb_router_pkt_gen.sv
// Directed bench for router_pkt_gen: basic packet, busy stalls, rejects, full buffer, reset, gap.
module tb_router_pkt_gen;

    logic clock = 1'b0;
    logic resetn;

    router_pkt_gen_if bus ();

    router_pkt_gen #(
        .DEPTH      (64),
        .GAP_CYCLES (2)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [7:0]  exp_q [$];

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus.pld_valid = 1'b1;
        bus.pld_data  = b;
        step();
        bus.pld_valid = 1'b0;
    endtask

    task automatic start_cmd(input logic [1:0] a, input logic [5:0] l);
        bus.tx_start = 1'b1;
        bus.tx_addr  = a;
        bus.tx_len   = l;
        step();
        bus.tx_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int unsigned n = 0;
        while (!bus.tx_idle && n < 50) begin
            step();
            n++;
        end
        check({tag, " idle"}, {7'b0, bus.tx_idle}, 8'h01);
    endtask

    task automatic expect_out(input string tag, input logic [7:0] d, input logic pv);
        check({tag, " data"}, bus.data_in, d);
        check({tag, " pv"}, {7'b0, bus.pkt_valid}, {7'b0, pv});
    endtask

    // Sends a command and checks header, the payload in exp_q, parity and tx_done.
    task automatic run_pkt(input string tag, input logic [1:0] a, input logic [5:0] l,
                           input logic [7:0] hdr, input logic [7:0] par);
        start_cmd(a, l);
        expect_out({tag, " hdr"}, hdr, 1'b1);
        for (int i = 0; i < int'(l); i++) begin
            step();
            expect_out({tag, " pld"}, exp_q[i], 1'b1);
        end
        step();
        expect_out({tag, " par"}, par, 1'b0);
        step();
        check({tag, " done"}, {7'b0, bus.tx_done}, 8'h01);
        wait_idle(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1);
    end

    initial begin
        resetn        = 1'b0;
        bus.pld_data  = '0;
        bus.pld_valid = 1'b0;
        bus.tx_start  = 1'b0;
        bus.tx_addr   = '0;
        bus.tx_len    = '0;
        bus.busy      = 1'b0;
        #12;
        expect_out("rst", 8'h00, 1'b0);
        check("rst cmd_err", {7'b0, bus.cmd_err}, 8'h00);
        check("rst tx_done", {7'b0, bus.tx_done}, 8'h00);
        check("rst tx_idle", {7'b0, bus.tx_idle}, 8'h01);
        check("rst pld_ready", {7'b0, bus.pld_ready}, 8'h01);
        resetn = 1'b1;
        step();

        // Basic packet
        push_byte(8'h04); push_byte(8'h08); push_byte(8'h09);
        start_cmd(2'd0, 6'd3);
        expect_out("basic hdr", 8'h0C, 1'b1);
        check("basic idle0", {7'b0, bus.tx_idle}, 8'h00);
        step(); expect_out("basic b0", 8'h04, 1'b1);
        step(); expect_out("basic b1", 8'h08, 1'b1);
        step(); expect_out("basic b2", 8'h09, 1'b1);
        step(); expect_out("basic par", 8'h09, 1'b0);
        check("basic done early", {7'b0, bus.tx_done}, 8'h00);
        step(); expect_out("basic gap1", 8'h00, 1'b0);
        check("basic done", {7'b0, bus.tx_done}, 8'h01);
        check("basic gap1 idle", {7'b0, bus.tx_idle}, 8'h00);
        step();
        check("basic done pulse", {7'b0, bus.tx_done}, 8'h00);
        check("basic gap2 idle", {7'b0, bus.tx_idle}, 8'h00);
        step();
        check("basic back idle", {7'b0, bus.tx_idle}, 8'h01);

        // Busy stalls on header and parity
        push_byte(8'h04); push_byte(8'h08); push_byte(8'h09);
        start_cmd(2'd1, 6'd3);
        expect_out("stall hdr", 8'h0D, 1'b1);
        bus.busy = 1'b1;
        repeat (3) begin step(); expect_out("stall hdr hold", 8'h0D, 1'b1); end
        bus.busy = 1'b0;
        step(); expect_out("stall b0", 8'h04, 1'b1);
        step(); expect_out("stall b1", 8'h08, 1'b1);
        step(); expect_out("stall b2", 8'h09, 1'b1);
        step(); expect_out("stall par", 8'h08, 1'b0);
        bus.busy = 1'b1;
        repeat (2) begin
            step();
            expect_out("stall par hold", 8'h08, 1'b0);
            check("stall no done", {7'b0, bus.tx_done}, 8'h00);
        end
        bus.busy = 1'b0;
        step();
        check("stall done", {7'b0, bus.tx_done}, 8'h01);
        wait_idle("stall");

        // Rejected commands leave the buffer intact
        push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC);
        start_cmd(2'd3, 6'd3);
        check("rej addr err", {7'b0, bus.cmd_err}, 8'h01);
        expect_out("rej addr", 8'h00, 1'b0);
        check("rej addr idle", {7'b0, bus.tx_idle}, 8'h01);
        step();
        check("rej err pulse", {7'b0, bus.cmd_err}, 8'h00);
        start_cmd(2'd0, 6'd0);
        check("rej len0 err", {7'b0, bus.cmd_err}, 8'h01);
        expect_out("rej len0", 8'h00, 1'b0);
        step();
        start_cmd(2'd0, 6'd5);
        check("rej short err", {7'b0, bus.cmd_err}, 8'h01);
        expect_out("rej short", 8'h00, 1'b0);
        check("rej short idle", {7'b0, bus.tx_idle}, 8'h01);
        step();
        exp_q = '{8'hAA, 8'hBB, 8'hCC};
        run_pkt("rej after", 2'd2, 6'd3, 8'h0E, 8'hD3);

        // Full buffer, dropped write, max-length packet with concurrent push/pop
        for (int i = 1; i <= 64; i++) push_byte(8'(i));
        check("full ready", {7'b0, bus.pld_ready}, 8'h00);
        push_byte(8'hEE);
        start_cmd(2'd1, 6'd63);
        expect_out("full hdr", 8'hFD, 1'b1);
        step();
        for (int k = 1; k <= 63; k++) begin
            expect_out("full pld", 8'(k), 1'b1);
            if (k <= 10) begin
                bus.pld_valid = 1'b1;
                bus.pld_data  = 8'(8'h80 + k - 1);
            end else begin
                bus.pld_valid = 1'b0;
            end
            step();
            if (k <= 10) check("full pushpop ready", {7'b0, bus.pld_ready}, 8'h01);
        end
        bus.pld_valid = 1'b0;
        expect_out("full par", 8'hFD, 1'b0);
        step();
        check("full done", {7'b0, bus.tx_done}, 8'h01);
        wait_idle("full");
        check("full ready again", {7'b0, bus.pld_ready}, 8'h01);
        exp_q = '{8'h40, 8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h88, 8'h89};
        run_pkt("residue", 2'd2, 6'd11, 8'h2E, 8'h6F);

        // Reset mid-packet
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
        start_cmd(2'd0, 6'd3);
        step();
        step();
        expect_out("mid pld", 8'h22, 1'b1);
        #2 resetn = 1'b0;
        #1;
        expect_out("mid rst", 8'h00, 1'b0);
        check("mid rst idle", {7'b0, bus.tx_idle}, 8'h01);
        check("mid rst ready", {7'b0, bus.pld_ready}, 8'h01);
        step();
        step();
        resetn = 1'b1;
        step();
        push_byte(8'h5A); push_byte(8'hA5); push_byte(8'h3C);
        exp_q = '{8'h5A, 8'hA5, 8'h3C};
        run_pkt("post rst", 2'd2, 6'd3, 8'h0E, 8'hCD);

        // Command during the gap is ignored; reissue when idle
        push_byte(8'h01); push_byte(8'h02); push_byte(8'h03); push_byte(8'h77);
        start_cmd(2'd1, 6'd3);
        expect_out("b2b hdr", 8'h0D, 1'b1);
        repeat (3) step();
        step(); expect_out("b2b par", 8'h0D, 1'b0);
        step();
        check("b2b done", {7'b0, bus.tx_done}, 8'h01);
        start_cmd(2'd0, 6'd1);
        check("b2b gap no err", {7'b0, bus.cmd_err}, 8'h00);
        expect_out("b2b gap", 8'h00, 1'b0);
        check("b2b gap busy", {7'b0, bus.tx_idle}, 8'h00);
        step();
        check("b2b gap end no err", {7'b0, bus.cmd_err}, 8'h00);
        expect_out("b2b gap end", 8'h00, 1'b0);
        check("b2b idle", {7'b0, bus.tx_idle}, 8'h01);
        exp_q = '{8'h77};
        run_pkt("b2b second", 2'd0, 6'd1, 8'h04, 8'h73);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
